dmem_ctrl: RTL

- Responder to the control unit's data-memory and address-stepping strobes: dmem_read, dmem_write, mar_inc, col_inc, row_inc and col_zero.
- Holds the memory address register (MAR) plus row/column counters, forms the effective data-memory address, and sequences the synchronous data RAM.
- Returns read data to the datapath in a data register (DR).
- Sits between the control unit, the datapath bus and the data RAM.

---
 rtl/dmem_ctrl_pkg.sv | 26 ++
 rtl/dmem_ctrl_edge.sv | 21 ++
 rtl/dmem_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/dmem_ctrl_pkg.sv
// Shared types and default widths for the data-memory controller.
// Holds the FSM state encoding and the strobe bit positions.
package dmem_ctrl_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 12;
  localparam int DEF_ROW_W  = 4;
  localparam int DEF_COL_W  = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RD_REQ = 2'd1,
    S_RD_CAP = 2'd2,
    S_WR     = 2'd3
  } state_t;

  localparam int NSTB  = 7;
  localparam int B_RD  = 0;
  localparam int B_WR  = 1;
  localparam int B_MI  = 2;
  localparam int B_CI  = 3;
  localparam int B_RI  = 4;
  localparam int B_CZ  = 5;
  localparam int B_LD  = 6;

endpackage

// File: rtl/dmem_ctrl_edge.sv
// N-bit rising-edge detector with synchronous active-high reset.
// Ports: clk, reset, sig (levels), rise (one-cycle 0->1 pulses).
module strobe_edge #(
  parameter int N = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] sig,
  output logic [N-1:0] rise
);

  logic [N-1:0] prev;

  always_ff @(posedge clk) begin
    if (reset) prev <= '0;
    else       prev <= sig;
  end

  assign rise = sig & ~prev;

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: MAR/row/col counters, address forming, RAM sequencing.
// Ports: strobes in, bus_in/mem_rdata in; mem_* to RAM, dr/dr_valid/busy/err out.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int ROW_W  = DEF_ROW_W,
  parameter int COL_W  = DEF_COL_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dmem_read,
  input  logic              dmem_write,
  input  logic              mar_inc,
  input  logic              col_inc,
  input  logic              row_inc,
  input  logic              col_zero,
  input  logic              mar_load,
  input  logic [DATA_W-1:0] bus_in,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] dr,
  output logic              dr_valid,
  output logic              busy,
  output logic              err
);

  logic [NSTB-1:0]   stb;
  logic [NSTB-1:0]   rise;
  logic [ADDR_W-1:0] mar;
  logic [ROW_W-1:0]  row;
  logic [COL_W-1:0]  col;
  logic [ADDR_W-1:0] eff;
  logic [DATA_W-1:0] dr_q;
  logic              rd_e;
  logic              wr_e;
  logic              acc_rd;
  logic              acc_wr;
  logic              unused;
  state_t            state_q;
  state_t            state_d;

  assign stb = {mar_load, col_zero, row_inc, col_inc,
                mar_inc, dmem_write, dmem_read};

  strobe_edge #(.N(NSTB)) u_edge (
    .clk   (clk),
    .reset (reset),
    .sig   (stb),
    .rise  (rise)
  );

  assign unused = ^bus_in;

  assign rd_e = rise[B_RD];
  assign wr_e = rise[B_WR];

  // Requests use the pre-update counters
  assign eff = mar
             + (ADDR_W'(row) << COL_W)
             + ADDR_W'(col);

  assign acc_rd = rd_e & ~wr_e & ~busy;
  assign acc_wr = wr_e & ~rd_e & ~busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      mar <= '0;
      row <= '0;
      col <= '0;
    end else begin
      if (rise[B_LD])
        mar <= bus_in[ADDR_W-1:0];
      else if (rise[B_MI])
        mar <= mar + ADDR_W'(1);
      if (rise[B_RI])
        row <= row + ROW_W'(1);
      if (rise[B_CZ])
        col <= '0;
      else if (rise[B_CI])
        col <= col + COL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (acc_rd)      state_d = S_RD_REQ;
        else if (acc_wr) state_d = S_WR;
      end
      S_RD_REQ: state_d = S_RD_CAP;
      S_RD_CAP: state_d = S_IDLE;
      S_WR:     state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_rd   = 1'b0;
    mem_we   = 1'b0;
    dr_valid = 1'b0;
    busy     = 1'b0;
    unique case (state_q)
      S_IDLE:   ;
      S_RD_REQ: begin
        mem_rd = 1'b1;
        busy   = 1'b1;
      end
      S_RD_CAP: begin
        dr_valid = 1'b1;
        busy     = 1'b1;
      end
      S_WR: begin
        mem_we = 1'b1;
        busy   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      dr_q      <= '0;
      err       <= 1'b0;
    end else begin
      if (acc_rd | acc_wr)
        mem_addr <= eff;
      if (acc_wr)
        mem_wdata <= bus_in;
      if (state_q == S_RD_CAP)
        dr_q <= mem_rdata;
      if ((rd_e & wr_e) | ((rd_e | wr_e) & busy))
        err <= 1'b1;
    end
  end

  // RAM data is presented in the capture cycle itself, then held
  assign dr = dr_valid ? mem_rdata : dr_q;

endmodule
